// File: rtl/fp_rf_write_arbiter.sv
// fp_rf_write_arbiter
// Write-side front end for the recoded-FP physical register file. It merges
// three writeback sources onto the W0/W1 write ports through one registered
// write stage:
//   - FPU pipe: fixed latency, no backpressure, always lands on W0.
//   - div/sqrt: valid/ready handshake; div_ready is its combinational grant.
//   - long-latency load: buffered in an LL_DEPTH FIFO, head competes for a port.
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   fpu_valid/pdst/data   FPU writeback (no stall)
//   div_valid/ready/pdst/data  div/sqrt writeback handshake
//   ll_valid/ready/pdst/data   load writeback into the FIFO
//   W0_*/W1_*             registered register-file write ports
//   wake0_*/wake1_*       issue-stage wakeups, mirrors of W0/W1
//   wb_conflict           sticky flag: both ports wrote the same preg
module fp_rf_write_arbiter #(
   parameter int NUM_PREGS = 96,
   parameter int PREG_W    = 7,
   parameter int DATA_W    = 65,
   parameter int LL_DEPTH  = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              fpu_valid,
   input  logic [PREG_W-1:0] fpu_pdst,
   input  logic [DATA_W-1:0] fpu_data,
   input  logic              div_valid,
   output logic              div_ready,
   input  logic [PREG_W-1:0] div_pdst,
   input  logic [DATA_W-1:0] div_data,
   input  logic              ll_valid,
   output logic              ll_ready,
   input  logic [PREG_W-1:0] ll_pdst,
   input  logic [DATA_W-1:0] ll_data,
   output logic              W0_en,
   output logic [PREG_W-1:0] W0_addr,
   output logic [DATA_W-1:0] W0_data,
   output logic              W1_en,
   output logic [PREG_W-1:0] W1_addr,
   output logic [DATA_W-1:0] W1_data,
   output logic              wake0_valid,
   output logic [PREG_W-1:0] wake0_pdst,
   output logic              wake1_valid,
   output logic [PREG_W-1:0] wake1_pdst,
   output logic              wb_conflict
);

   localparam int PTR_W = $clog2(LL_DEPTH);
   localparam int CNT_W = $clog2(LL_DEPTH + 1);
   localparam logic [CNT_W-1:0]  FULL = CNT_W'(LL_DEPTH);
   localparam logic [PREG_W:0]   NPR  = (PREG_W + 1)'(NUM_PREGS);

   typedef struct packed {
      logic [PREG_W-1:0] pdst;
      logic [DATA_W-1:0] data;
   } wb_t;

   typedef struct packed {
      logic en;
      wb_t  wb;
   } wport_t;

   wb_t              ll_mem [LL_DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [CNT_W-1:0] count;
   logic             rr;            // 0: div preferred, 1: load head preferred
   wport_t           w0_q, w1_q, w0_d, w1_d;
   wb_t              fpu_wb, div_wb, ll_wb, llh_wb;
   logic             llh_vld, grant_div, grant_llh, contested, enq, deq;
   logic             conflict_now;

   assign fpu_wb  = {fpu_pdst, fpu_data};
   assign div_wb  = {div_pdst, div_data};
   assign ll_wb   = {ll_pdst, ll_data};
   assign llh_wb  = ll_mem[rd_ptr];
   assign llh_vld = (count != '0);

   // Full is judged from the registered count alone, so a full FIFO refuses
   // a load even in a cycle where its head drains.
   assign ll_ready = !reset && (count != FULL);
   assign enq      = ll_valid && ll_ready;
   assign deq      = grant_llh;

   // Only a contest (FPU holds W0, both div and load head want W1) consults
   // rr; every other case has a port for each candidate.
   always_comb begin
      grant_div = 1'b0;
      grant_llh = 1'b0;
      contested = 1'b0;
      if (!reset) begin
         contested = fpu_valid && div_valid && llh_vld;
         if (contested) begin
            grant_div = !rr;
            grant_llh = rr;
         end else begin
            grant_div = div_valid;
            grant_llh = llh_vld;
         end
      end
   end

   assign div_ready = grant_div;

   // Port steering: FPU owns W0; div falls to W1 when the FPU is present.
   always_comb begin
      w0_d = '0;
      w1_d = '0;
      if (fpu_valid)      w0_d = '{en: 1'b1, wb: fpu_wb};
      else if (grant_div) w0_d = '{en: 1'b1, wb: div_wb};
      if (fpu_valid && grant_div) w1_d = '{en: 1'b1, wb: div_wb};
      else if (grant_llh)         w1_d = '{en: 1'b1, wb: llh_wb};
   end

   assign conflict_now = w0_q.en && w1_q.en && (w0_q.wb.pdst == w1_q.wb.pdst);

   always_ff @(posedge clock) begin
      if (reset) begin
         w0_q.en     <= 1'b0;
         w1_q.en     <= 1'b0;
         rr          <= 1'b0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         wb_conflict <= 1'b0;
      end else begin
         w0_q <= w0_d;
         w1_q <= w1_d;
         // after a contest rr points at the loser
         if (contested) rr <= ~rr;
         if (enq) wr_ptr <= wr_ptr + 1'b1;
         if (deq) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(enq) - CNT_W'(deq);
         if (conflict_now) wb_conflict <= 1'b1;
      end
   end

   // FIFO storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clock) begin
      if (enq) ll_mem[wr_ptr] <= ll_wb;
   end

   assign W0_en       = w0_q.en;
   assign W0_addr     = w0_q.wb.pdst;
   assign W0_data     = w0_q.wb.data;
   assign W1_en       = w1_q.en;
   assign W1_addr     = w1_q.wb.pdst;
   assign W1_data     = w1_q.wb.data;
   assign wake0_valid = w0_q.en;
   assign wake0_pdst  = w0_q.wb.pdst;
   assign wake1_valid = w1_q.en;
   assign wake1_pdst  = w1_q.wb.pdst;

   // Same-preg double write is legal to issue but indicates a rename bug.
   a_same_addr: assert property (@(posedge clock) disable iff (reset) !conflict_now)
      else $warning("wb_conflict: W0 and W1 both wrote preg %0d", W0_addr);

   a_fpu_pdst: assert property (@(posedge clock) disable iff (reset)
      !(fpu_valid && ({1'b0, fpu_pdst} >= NPR)));
   a_div_pdst: assert property (@(posedge clock) disable iff (reset)
      !(div_valid && ({1'b0, div_pdst} >= NPR)));
   a_ll_pdst: assert property (@(posedge clock) disable iff (reset)
      !(ll_valid && ({1'b0, ll_pdst} >= NPR)));

endmodule
